dm_sba_csr: RTL
===============

// Module: dm_sba_csr
// PURPOSE
// - DMI-facing register front-end of System Bus Access: implements SBCS, SBADDRESS0/1, SBDATA0/1.
// - Decodes DMI reads/writes, holds SBA config/address/data, emits single-cycle trigger pulses to dm_sba.
// - Captures bus read data, auto-incremented address and bus errors returned by dm_sba; sits between DMI and dm_sba.
// PARAMETERS
// - BusWidth  32  system bus width; only 32 or 64 legal (64 adds SBADDRESS1/SBDATA1)
// - TimeoutCycles  1024  watchdog limit, used only with DM_SBA_TIMEOUT_EN
// PORTS
// - clk_i  in  1  clock
// - rst_ni  in  1  asynchronous reset, active-low
// - dmactive_i  in  1  synchronous clear of all state when low
// - dmi_req_valid_i / dmi_req_ready_o  in/out  1  DMI request handshake
// - dmi_req_addr_i  in  7  register address; dmi_req_op_i  in  2  0 nop, 1 read, 2 write
// - dmi_req_data_i  in  32  write data
// - dmi_resp_valid_o / dmi_resp_ready_i  out/in  1  response handshake; dmi_resp_data_o  out  32
// - sbaddress_o  out  BusWidth  current address to dm_sba; sbaddress_i  in  BusWidth  next address from dm_sba
// - sbaddress_write_valid_o / sbdata_write_valid_o / sbdata_read_valid_o  out  1  one-cycle triggers
// - sbreadonaddr_o, sbautoincrement_o, sbreadondata_o  out  1; sbaccess_o  out  3  SBCS fields
// - sbdata_o  out  BusWidth  write data; sbdata_i  in  BusWidth, sbdata_valid_i  in  1  bus response
// - sbbusy_i  in  1; sberror_valid_i  in  1; sberror_i  in  3  status from dm_sba
// BEHAVIOUR
// - Map: 0x38 SBCS, 0x39 SBADDRESS0, 0x3A SBADDRESS1, 0x3C SBDATA0, 0x3D SBDATA1; others read 0, writes ignored.
// - SBCS: [31:29] version=1, [22] sbbusyerror W1C, [21] sbbusy=sbbusy_i, [20] readonaddr, [19:17] access,
//   [16] autoincrement, [15] readondata, [14:12] sberror W1C, [11:5] BusWidth, [4:0] 64b:5'b01111 / 32b:5'b00111.
// - DMI: ready_o = !resp_pending; accepted request -> resp_valid_o next cycle, held until resp_ready_i.
//   nop returns 0. Register writes take effect on the accept edge; reads sample pre-write state.
// - Trigger gating: blocked = sbbusyerror_q | (sberror_q != 0).
//   - SBADDRESS0 write: if sbbusy_i -> set sbbusyerror, no update; else store; pulse sbaddress_write_valid_o if !blocked.
//   - SBDATA0 write: if sbbusy_i -> set sbbusyerror; else store; pulse sbdata_write_valid_o if !blocked.
//   - SBDATA0 read: if sbbusy_i -> set sbbusyerror, return stale data; else pulse sbdata_read_valid_o if !blocked.
//   - SBADDRESS1/SBDATA1: store upper word only, never trigger (64b build; read 0 in 32b build).
// - Pulses last exactly one cycle, asserted the cycle after request acceptance.
// - Bus response: sbdata_valid_i & read pending -> sbdata_q <= sbdata_i; any sbdata_valid_i -> sbaddress_q <= sbaddress_i.
//   Read-pending flag set with sbdata_read_valid_o or readonaddr trigger, cleared on sbdata_valid_i.
// - sberror_valid_i latches sberror_i only if sberror_q == 0 (first error sticky).
// - Same-cycle hardware set and DMI W1C on sberror/sbbusyerror: set wins.
// - Reset/dmactive_i low: all regs 0 except sbaccess=3'd2; all outputs 0, resp_valid_o 0, ready_o 1.
//   Reset mid-transaction drops pending response and read-pending flag.
// CONFIGURATION
// - DM_SBA_TIMEOUT_EN defined: counter runs while sbbusy_i, clears when idle; on reaching TimeoutCycles
//   sets sberror=1 (if 0) once per transaction. Undefined: no counter, sberror=1 never generated locally.
// STRUCTURE
// - dm_sba_pkg: register address localparams, sbcs_t packed struct, dmi_op_e enum, SBVERSION constant.
// - Optional sub-module dm_sba_watchdog (timeout counter), instantiated only under DM_SBA_TIMEOUT_EN.
// TESTING
// - Write SBADDRESS0=0x1000 with readonaddr=1, access=2 -> one sbaddress_write_valid_o pulse, sbaddress_o=0x1000.
// - Read completes: sbdata_valid_i with sbdata_i=0xDEADBEEF, sbaddress_i=0x1004 -> SBDATA0 reads 0xDEADBEEF, SBADDRESS0 0x1004.
// - SBDATA0 write while sbbusy_i=1 -> no pulse, SBCS[22]=1; later writes ignored until W1C 1<<22.
// - sberror_valid_i, sberror_i=3 -> SBCS[14:12]=3; second error 2 ignored; W1C 0x7000 same cycle as new error -> stays 3.
// - 32b build: SBCS reads 0x2004_0407 after reset; SBADDRESS1 reads 0; 64b build SBCS[11:5]=64, [4:0]=0xF.
// - With DM_SBA_TIMEOUT_EN, TimeoutCycles=8, sbbusy_i held 8 cycles -> sberror=1; macro off -> sberror stays 0.

Source files
------------

// File: rtl/dm_sba_pkg.sv
// Shared definitions for the system bus access register front-end:
// DMI register map, SBCS layout and DMI opcode encoding.
package dm_sba_pkg;

   localparam logic [6:0] ADDR_SBCS       = 7'h38;
   localparam logic [6:0] ADDR_SBADDRESS0 = 7'h39;
   localparam logic [6:0] ADDR_SBADDRESS1 = 7'h3A;
   localparam logic [6:0] ADDR_SBDATA0    = 7'h3C;
   localparam logic [6:0] ADDR_SBDATA1    = 7'h3D;

   localparam logic [2:0] SBVERSION      = 3'd1;
   localparam logic [2:0] SBACCESS_RESET = 3'd2;

   typedef enum logic [1:0] {
      DMI_NOP   = 2'd0,
      DMI_READ  = 2'd1,
      DMI_WRITE = 2'd2
   } dmi_op_e;

   typedef struct packed {
      logic [2:0] sbversion;
      logic [5:0] zero0;
      logic       sbbusyerror;
      logic       sbbusy;
      logic       sbreadonaddr;
      logic [2:0] sbaccess;
      logic       sbautoincrement;
      logic       sbreadondata;
      logic [2:0] sberror;
      logic [6:0] sbasize;
      logic [4:0] sbaccess_sizes;
   } sbcs_t;

endpackage

// File: rtl/dm_sba_watchdog.sv
// System bus watchdog: raises timeout for one cycle once a busy period
// reaches TimeoutCycles cycles; reloads whenever the bus goes idle.
module dm_sba_watchdog #(
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear,
   input  logic busy,
   output logic timeout
);

   localparam int unsigned    CntW    = $clog2(TimeoutCycles + 1);
   localparam logic [CntW-1:0] CntLoad = CntW'(TimeoutCycles);

   logic [CntW-1:0] cnt_q;

   // Down-counter parks at zero after firing so a long busy period flags only once.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= CntLoad;
      end else if (clear || !busy) begin
         cnt_q <= CntLoad;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CntW'(1);
      end
   end

   assign timeout = busy && !clear && (cnt_q == CntW'(1));

endmodule

// File: rtl/dm_sba_csr.sv
// DMI register front-end of system bus access (SBCS, SBADDRESS0/1, SBDATA0/1).
// Define DM_SBA_TIMEOUT_EN to add the local bus watchdog (dm_sba_watchdog).
module dm_sba_csr
   import dm_sba_pkg::*;
#(
   parameter int unsigned BusWidth      = 32,
   parameter int unsigned TimeoutCycles = 1024
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                dmactive_i,
   input  logic                dmi_req_valid_i,
   output logic                dmi_req_ready_o,
   input  logic [6:0]          dmi_req_addr_i,
   input  logic [1:0]          dmi_req_op_i,
   input  logic [31:0]         dmi_req_data_i,
   output logic                dmi_resp_valid_o,
   input  logic                dmi_resp_ready_i,
   output logic [31:0]         dmi_resp_data_o,
   output logic [BusWidth-1:0] sbaddress_o,
   input  logic [BusWidth-1:0] sbaddress_i,
   output logic                sbaddress_write_valid_o,
   output logic                sbreadonaddr_o,
   output logic                sbautoincrement_o,
   output logic [2:0]          sbaccess_o,
   output logic                sbreadondata_o,
   output logic [BusWidth-1:0] sbdata_o,
   output logic                sbdata_write_valid_o,
   output logic                sbdata_read_valid_o,
   input  logic [BusWidth-1:0] sbdata_i,
   input  logic                sbdata_valid_i,
   input  logic                sbbusy_i,
   input  logic                sberror_valid_i,
   input  logic [2:0]          sberror_i
);

   logic        resp_valid_q, read_pending_q;
   logic [31:0] resp_data_q, sbaddress_lo_q, sbdata_lo_q, sbaddress_hi, sbdata_hi;
   logic        readonaddr_q, autoinc_q, readondata_q, sbbusyerror_q;
   logic [2:0]  access_q, sberror_q;
   logic        addr_pulse_q, data_wr_pulse_q, data_rd_pulse_q;

   logic        accept, wr_en, rd_en, blocked, timeout, hw_err, busy_violation;
   logic        wr_sbcs, wr_addr0, wr_data0, rd_data0;
   logic [2:0]  hw_err_val;
   logic [31:0] rd_data;
   dmi_op_e     req_op;
   sbcs_t       sbcs_rd;

   assign req_op  = dmi_op_e'(dmi_req_op_i);
   assign accept  = dmi_req_valid_i && !resp_valid_q;
   assign wr_en   = accept && (req_op == DMI_WRITE);
   assign rd_en   = accept && (req_op == DMI_READ);
   assign blocked = sbbusyerror_q || (sberror_q != 3'd0);

   assign wr_sbcs  = wr_en && (dmi_req_addr_i == ADDR_SBCS);
   assign wr_addr0 = wr_en && (dmi_req_addr_i == ADDR_SBADDRESS0);
   assign wr_data0 = wr_en && (dmi_req_addr_i == ADDR_SBDATA0);
   assign rd_data0 = rd_en && (dmi_req_addr_i == ADDR_SBDATA0);
   assign busy_violation = sbbusy_i && (wr_addr0 || wr_data0 || rd_data0);

`ifdef DM_SBA_TIMEOUT_EN
   dm_sba_watchdog #(.TimeoutCycles(TimeoutCycles)) u_watchdog (
      .clk_i,
      .rst_ni,
      .clear   (!dmactive_i),
      .busy    (sbbusy_i),
      .timeout (timeout)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TimeoutCycles;
   assign timeout = 1'b0;
`endif

   // A locally detected timeout is reported as sberror 1 (bus timeout).
   assign hw_err     = sberror_valid_i || timeout;
   assign hw_err_val = sberror_valid_i ? sberror_i : 3'd1;

   always_comb begin
      sbcs_rd                 = '0;
      sbcs_rd.sbversion       = SBVERSION;
      sbcs_rd.sbbusyerror     = sbbusyerror_q;
      sbcs_rd.sbbusy          = sbbusy_i;
      sbcs_rd.sbreadonaddr    = readonaddr_q;
      sbcs_rd.sbaccess        = access_q;
      sbcs_rd.sbautoincrement = autoinc_q;
      sbcs_rd.sbreadondata    = readondata_q;
      sbcs_rd.sberror         = sberror_q;
      sbcs_rd.sbasize         = 7'(BusWidth);
      sbcs_rd.sbaccess_sizes  = (BusWidth == 64) ? 5'b01111 : 5'b00111;
   end

   always_comb begin
      case (dmi_req_addr_i)
         ADDR_SBCS:       rd_data = sbcs_rd;
         ADDR_SBADDRESS0: rd_data = sbaddress_lo_q;
         ADDR_SBADDRESS1: rd_data = sbaddress_hi;
         ADDR_SBDATA0:    rd_data = sbdata_lo_q;
         ADDR_SBDATA1:    rd_data = sbdata_hi;
         default:         rd_data = '0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         resp_valid_q    <= 1'b0;
         resp_data_q     <= '0;
         sbaddress_lo_q  <= '0;
         sbdata_lo_q     <= '0;
         readonaddr_q    <= 1'b0;
         autoinc_q       <= 1'b0;
         readondata_q    <= 1'b0;
         access_q        <= SBACCESS_RESET;
         sbbusyerror_q   <= 1'b0;
         sberror_q       <= '0;
         addr_pulse_q    <= 1'b0;
         data_wr_pulse_q <= 1'b0;
         data_rd_pulse_q <= 1'b0;
         read_pending_q  <= 1'b0;
      end else if (!dmactive_i) begin
         resp_valid_q    <= 1'b0;
         resp_data_q     <= '0;
         sbaddress_lo_q  <= '0;
         sbdata_lo_q     <= '0;
         readonaddr_q    <= 1'b0;
         autoinc_q       <= 1'b0;
         readondata_q    <= 1'b0;
         access_q        <= SBACCESS_RESET;
         sbbusyerror_q   <= 1'b0;
         sberror_q       <= '0;
         addr_pulse_q    <= 1'b0;
         data_wr_pulse_q <= 1'b0;
         data_rd_pulse_q <= 1'b0;
         read_pending_q  <= 1'b0;
      end else begin
         addr_pulse_q    <= 1'b0;
         data_wr_pulse_q <= 1'b0;
         data_rd_pulse_q <= 1'b0;

         if (resp_valid_q && dmi_resp_ready_i) resp_valid_q <= 1'b0;
         if (accept) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= rd_en ? rd_data : 32'd0;
         end

         if (sbdata_valid_i) begin
            sbaddress_lo_q <= sbaddress_i[31:0];
            read_pending_q <= 1'b0;
            if (read_pending_q) sbdata_lo_q <= sbdata_i[31:0];
         end

         // A hardware error in the same cycle as a W1C suppresses the clear.
         if (hw_err) begin
            if (sberror_q == 3'd0) sberror_q <= hw_err_val;
         end else if (wr_sbcs) begin
            sberror_q <= sberror_q & ~dmi_req_data_i[14:12];
         end

         if (busy_violation)                  sbbusyerror_q <= 1'b1;
         else if (wr_sbcs && dmi_req_data_i[22]) sbbusyerror_q <= 1'b0;

         if (wr_sbcs) begin
            readonaddr_q <= dmi_req_data_i[20];
            access_q     <= dmi_req_data_i[19:17];
            autoinc_q    <= dmi_req_data_i[16];
            readondata_q <= dmi_req_data_i[15];
         end

         if (wr_addr0 && !sbbusy_i) begin
            sbaddress_lo_q <= dmi_req_data_i;
            if (!blocked) begin
               addr_pulse_q <= 1'b1;
               if (readonaddr_q) read_pending_q <= 1'b1;
            end
         end

         if (wr_data0 && !sbbusy_i) begin
            sbdata_lo_q <= dmi_req_data_i;
            if (!blocked) data_wr_pulse_q <= 1'b1;
         end

         if (rd_data0 && !sbbusy_i && !blocked) begin
            data_rd_pulse_q <= 1'b1;
            read_pending_q  <= 1'b1;
         end
      end
   end

   if (BusWidth == 64) begin : g_bus64
      logic [31:0] sbaddress_hi_q, sbdata_hi_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            sbaddress_hi_q <= '0;
            sbdata_hi_q    <= '0;
         end else if (!dmactive_i) begin
            sbaddress_hi_q <= '0;
            sbdata_hi_q    <= '0;
         end else begin
            if (sbdata_valid_i) begin
               sbaddress_hi_q <= sbaddress_i[63:32];
               if (read_pending_q) sbdata_hi_q <= sbdata_i[63:32];
            end
            if (wr_en && (dmi_req_addr_i == ADDR_SBADDRESS1)) sbaddress_hi_q <= dmi_req_data_i;
            if (wr_en && (dmi_req_addr_i == ADDR_SBDATA1))    sbdata_hi_q    <= dmi_req_data_i;
         end
      end

      assign sbaddress_hi = sbaddress_hi_q;
      assign sbdata_hi    = sbdata_hi_q;
      assign sbaddress_o  = {sbaddress_hi_q, sbaddress_lo_q};
      assign sbdata_o     = {sbdata_hi_q, sbdata_lo_q};
   end else begin : g_bus32
      assign sbaddress_hi = '0;
      assign sbdata_hi    = '0;
      assign sbaddress_o  = sbaddress_lo_q;
      assign sbdata_o     = sbdata_lo_q;
   end

   assign dmi_req_ready_o         = !resp_valid_q;
   assign dmi_resp_valid_o        = resp_valid_q;
   assign dmi_resp_data_o         = resp_data_q;
   assign sbaddress_write_valid_o = addr_pulse_q;
   assign sbdata_write_valid_o    = data_wr_pulse_q;
   assign sbdata_read_valid_o     = data_rd_pulse_q;
   assign sbreadonaddr_o          = readonaddr_q;
   assign sbautoincrement_o       = autoinc_q;
   assign sbaccess_o              = access_q;
   assign sbreadondata_o          = readondata_q;

endmodule
